// File: rtl/regfile_pkg.sv
// regfile_pkg: shared constants and writeback request type for the register-file writeback path
package regfile_pkg;
  localparam int WIDTH_DEF = 32;
  localparam int DEPTH_DEF = 32;
  localparam int ADDR_W = $clog2(DEPTH_DEF);
  localparam int ZERO_REG = 0;
  typedef struct packed {
    logic valid;
    logic [ADDR_W-1:0] addr;
    logic [WIDTH_DEF-1:0] data;
  } wb_req_t;
endpackage

// File: rtl/wb_scoreboard.sv
// wb_scoreboard: pending-write busy bits with set-wins update and two RAW hazard query ports
module wb_scoreboard
  import regfile_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          set_valid,
  input  logic [AW-1:0] set_addr,
  input  logic          clr_valid,
  input  logic [AW-1:0] clr_addr,
  input  logic          wb_we,
  input  logic [AW-1:0] wb_addr,
  input  logic [AW-1:0] chk_addr0,
  input  logic [AW-1:0] chk_addr1,
  output logic          chk_busy0,
  output logic          chk_busy1
);
  logic [DEPTH-1:0] busy_q, busy_d;
  always_comb begin
    for (int i = 0; i < DEPTH; i++)
      busy_d[i] = (i != ZERO_REG) && ((set_valid && set_addr == AW'(i)) ||
                  (busy_q[i] && !(clr_valid && clr_addr == AW'(i))));
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) busy_q <= '0;
    else busy_q <= busy_d;
  end
  // a write sitting in the output register is still uncommitted in the register file
  assign chk_busy0 = busy_q[chk_addr0] | (wb_we && wb_addr == chk_addr0 && chk_addr0 != AW'(ZERO_REG));
  assign chk_busy1 = busy_q[chk_addr1] | (wb_we && wb_addr == chk_addr1 && chk_addr1 != AW'(ZERO_REG));
endmodule

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: arbitrates ALU and load writebacks onto the single register-file write port
module regfile_wb_arbiter
  import regfile_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int DEPTH = DEPTH_DEF,
  parameter int STARVE_MAX = 3,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             s0_valid,
  output logic             s0_ready,
  input  logic [AW-1:0]    s0_addr,
  input  logic [WIDTH-1:0] s0_data,
  input  logic             s1_valid,
  output logic             s1_ready,
  input  logic [AW-1:0]    s1_addr,
  input  logic [WIDTH-1:0] s1_data,
  input  logic             alloc_valid,
  input  logic [AW-1:0]    alloc_addr,
  input  logic [AW-1:0]    chk_addr0,
  input  logic [AW-1:0]    chk_addr1,
  output logic             chk_busy0,
  output logic             chk_busy1,
  output logic             we0,
  output logic [AW-1:0]    wr_addr0,
  output logic [WIDTH-1:0] wr_din0
);
  localparam int CW = $clog2(STARVE_MAX + 1);
  logic [CW-1:0] cnt_q, cnt_d;
  logic we0_q, we0_d, xfer, starve;
  logic [AW-1:0] wr_addr0_q, wr_addr0_d, sel_addr;
  logic [WIDTH-1:0] wr_din0_q, wr_din0_d, sel_data;
  // loads win by default; a starved ALU result overrides them once
  assign starve = cnt_q == CW'(STARVE_MAX);
  assign s0_ready = rst && s0_valid && (!s1_valid || starve);
  assign s1_ready = rst && s1_valid && !(s0_valid && starve);
  assign xfer = s0_ready | s1_ready;
  assign sel_addr = s0_ready ? s0_addr : s1_addr;
  assign sel_data = s0_ready ? s0_data : s1_data;
  always_comb begin
    cnt_d = s0_ready ? '0 : (s0_valid && !starve) ? cnt_q + 1'b1 : cnt_q;
    we0_d = xfer && sel_addr != AW'(ZERO_REG);
    wr_addr0_d = xfer ? sel_addr : wr_addr0_q;
    wr_din0_d = xfer ? sel_data : wr_din0_q;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
      we0_q <= 1'b0;
      wr_addr0_q <= '0;
      wr_din0_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      we0_q <= we0_d;
      wr_addr0_q <= wr_addr0_d;
      wr_din0_q <= wr_din0_d;
    end
  end
  assign we0 = we0_q;
  assign wr_addr0 = wr_addr0_q;
  assign wr_din0 = wr_din0_q;
  wb_scoreboard #(.DEPTH(DEPTH)) u_sb (
    .clk(clk),
    .rst(rst),
    .set_valid(alloc_valid),
    .set_addr(alloc_addr),
    .clr_valid(xfer),
    .clr_addr(sel_addr),
    .wb_we(we0_q),
    .wb_addr(wr_addr0_q),
    .chk_addr0(chk_addr0),
    .chk_addr1(chk_addr1),
    .chk_busy0(chk_busy0),
    .chk_busy1(chk_busy1)
  );
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb_regfile_wb_arbiter: directed scoreboard bench for regfile_wb_arbiter
module tb_regfile_wb_arbiter;
  import regfile_pkg::*;
  logic clk = 0, rst = 0;
  logic s0_valid = 0, s1_valid = 0, alloc_valid = 0;
  logic s0_ready, s1_ready, chk_busy0, chk_busy1, we0;
  logic [ADDR_W-1:0] s0_addr = 0, s1_addr = 0, alloc_addr = 0, chk_addr0 = 0, chk_addr1 = 0, wr_addr0;
  logic [WIDTH_DEF-1:0] s0_data = 0, s1_data = 0, wr_din0;
  int n_vec = 0, n_err = 0;
  wb_req_t exp_q[$];
  regfile_wb_arbiter dut (
    .clk(clk), .rst(rst),
    .s0_valid(s0_valid), .s0_ready(s0_ready), .s0_addr(s0_addr), .s0_data(s0_data),
    .s1_valid(s1_valid), .s1_ready(s1_ready), .s1_addr(s1_addr), .s1_data(s1_data),
    .alloc_valid(alloc_valid), .alloc_addr(alloc_addr),
    .chk_addr0(chk_addr0), .chk_addr1(chk_addr1), .chk_busy0(chk_busy0), .chk_busy1(chk_busy1),
    .we0(we0), .wr_addr0(wr_addr0), .wr_din0(wr_din0)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic tick(input bit r0, input bit r1);
    wb_req_t e, got;
    #1;
    chk("s0_ready", s0_ready, r0);
    chk("s1_ready", s1_ready, r1);
    e.valid = r0 ? (s0_addr != 0) : r1 ? (s1_addr != 0) : 1'b0;
    e.addr = r0 ? s0_addr : s1_addr;
    e.data = r0 ? s0_data : s1_data;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    chk("queue_nonempty", exp_q.size() != 0, 1);
    if (exp_q.size() != 0) begin
      got = exp_q.pop_front();
      chk("we0", we0, got.valid);
      if (got.valid) begin
        chk("wr_addr0", wr_addr0, got.addr);
        chk("wr_din0", wr_din0, got.data);
      end
    end
  endtask
  initial begin
    s0_valid = 1; s1_valid = 1;
    #2;
    chk("rst_we0", we0, 0);
    chk("rst_wr_addr0", wr_addr0, 0);
    chk("rst_wr_din0", wr_din0, 0);
    chk("rst_s0_ready", s0_ready, 0);
    chk("rst_s1_ready", s1_ready, 0);
    chk("rst_busy0", chk_busy0, 0);
    s0_valid = 0; s1_valid = 0;
    @(negedge clk); @(negedge clk);
    rst = 1;
    @(posedge clk); #1;
    s0_valid = 1; s0_addr = 5; s0_data = 32'hDEADBEEF;
    tick(1, 0);
    s0_valid = 0;
    tick(0, 0);
    s0_valid = 1; s0_addr = 3; s0_data = 32'hA0A0A0A0;
    s1_valid = 1; s1_addr = 7; s1_data = 32'h70;
    tick(0, 1);
    s1_addr = 8; s1_data = 32'h80;
    tick(0, 1);
    s1_addr = 9; s1_data = 32'h90;
    tick(0, 1);
    s1_addr = 10; s1_data = 32'hA0;
    tick(1, 0);
    s0_valid = 0;
    tick(0, 1);
    s1_addr = 11; s1_data = 32'hB0; s0_valid = 1; s0_addr = 4; s0_data = 32'h44;
    tick(0, 1);
    s0_valid = 0; s1_valid = 0;
    tick(0, 0);
    chk_addr0 = 0; s1_valid = 1; s1_addr = 0; s1_data = 32'h1234;
    alloc_valid = 1; alloc_addr = 0;
    #1 chk("x0_busy_before", chk_busy0, 0);
    tick(0, 1);
    chk("x0_busy_after", chk_busy0, 0);
    s1_valid = 0; alloc_valid = 0;
    alloc_valid = 1; alloc_addr = 10;
    tick(0, 0);
    alloc_valid = 0; chk_addr0 = 10;
    #1 chk("sb_alloc_busy", chk_busy0, 1);
    s0_valid = 1; s0_addr = 10; s0_data = 32'h55;
    tick(1, 0);
    chk("sb_inflight_busy", chk_busy0, 1);
    s0_valid = 0;
    tick(0, 0);
    chk("sb_cleared", chk_busy0, 0);
    alloc_valid = 1; alloc_addr = 12; chk_addr1 = 12;
    tick(0, 0);
    s1_valid = 1; s1_addr = 12; s1_data = 32'hC0FFEE;
    tick(0, 1);
    alloc_valid = 0; s1_valid = 0;
    chk("setwins_inflight", chk_busy1, 1);
    tick(0, 0);
    chk("setwins_busy", chk_busy1, 1);
    s0_valid = 1; s0_addr = 20; s0_data = 32'h77;
    alloc_valid = 1; alloc_addr = 21; chk_addr0 = 20; chk_addr1 = 21;
    tick(1, 0);
    alloc_valid = 0; s0_valid = 0;
    chk("pre_rst_busy0", chk_busy0, 1);
    chk("pre_rst_busy1", chk_busy1, 1);
    #2 rst = 0;
    #1;
    chk("midrst_we0", we0, 0);
    chk("midrst_busy0", chk_busy0, 0);
    chk("midrst_busy1", chk_busy1, 0);
    s0_valid = 1; s1_valid = 1;
    #1;
    chk("midrst_s0_ready", s0_ready, 0);
    chk("midrst_s1_ready", s1_ready, 0);
    @(posedge clk); #1;
    chk("midrst_hold_we0", we0, 0);
    chk("midrst_hold_s1_ready", s1_ready, 0);
    s0_valid = 0; s1_valid = 0;
    @(negedge clk);
    rst = 1;
    @(posedge clk); #1;
    chk("post_rst_busy1", chk_busy1, 0);
    s0_valid = 1; s0_addr = 20; s0_data = 32'h99;
    tick(1, 0);
    s0_valid = 0;
    tick(0, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
- Shares the single register-file write port (we0/wr_addr0/wr_din0) between two writeback sources: s0 = execute/ALU result, s1 = load-return from the memory unit.
- Keeps a pending-write scoreboard, allocated at issue and cleared at writeback, so decode can detect RAW hazards on rs1/rs2.
- Sits between the execute/LSU stages and the register file. Outputs are registered and drive the register file write port directly.

Parameters:
- WIDTH, 32, data width of a register.
- DEPTH, 32, number of architectural registers. Address width AW = $clog2(DEPTH).
- STARVE_MAX, 3, consecutive lost arbitration cycles after which s0 takes priority over s1.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset (rst=0 means reset).
- s0_valid  in  1  execute writeback request.
- s0_ready  out  1  execute request accepted this cycle.
- s0_addr  in  AW  execute destination register.
- s0_data  in  WIDTH  execute result.
- s1_valid  in  1  load writeback request.
- s1_ready  out  1  load request accepted this cycle.
- s1_addr  in  AW  load destination register.
- s1_data  in  WIDTH  load data.
- alloc_valid  in  1  issue marks a destination register pending.
- alloc_addr  in  AW  register to mark pending.
- chk_addr0  in  AW  hazard query address (rs1).
- chk_addr1  in  AW  hazard query address (rs2).
- chk_busy0  out  1  chk_addr0 has an outstanding write.
- chk_busy1  out  1  chk_addr1 has an outstanding write.
- we0  out  1  register file write enable, registered.
- wr_addr0  out  AW  register file write address, registered.
- wr_din0  out  WIDTH  register file write data, registered.

Behaviour:
- **Reset (rst=0, asynchronous):**
  - we0=0, wr_addr0=0, wr_din0=0.
  - All scoreboard busy bits 0, starvation counter 0.
  - s0_ready=0, s1_ready=0 and chk_busy0/1=0 while rst=0.
- **Handshake:**
  - Transfer occurs when sX_valid && sX_ready at a rising edge.
  - Ready is combinational from the valids and the counter. At most one ready is high per cycle.
  - A requester must hold valid, addr and data stable until ready.
  - The output stage drains every cycle, so a request is never refused for lack of space; only arbitration loss refuses it.
- **Arbitration:**
  - Default priority is s1 > s0, because the load unit cannot stall.
  - Starvation counter increments (saturating at STARVE_MAX) on each cycle with s0_valid && !s0_ready, and clears when s0 transfers.
  - When the counter equals STARVE_MAX, s0 wins even if s1_valid is high. s1 must wait and hold its request.
- **Latency:** a request accepted at edge N appears on we0/wr_addr0/wr_din0 during cycle N+1 and is written into the register file at edge N+1. With no transfer at edge N, we0=0 in cycle N+1.
- **x0:**
  - A request with addr=0 is accepted normally.
  - The registered we0 is forced to 0, so nothing is written.
  - The scoreboard ignores address 0.
  - chk_busy for address 0 is always 0.
- **Scoreboard:**
  - busy[a] is set at the edge with alloc_valid && alloc_addr=a (a≠0).
  - busy[a] is cleared at the edge where a writeback to a is accepted.
  - If set and clear hit the same address at the same edge, set wins (a newer producer is issued).
- **Hazard query (combinational):** chk_busyK = busy[chk_addrK] | (we0 && wr_addr0==chk_addrK && chk_addrK≠0). This covers the cycle in which the write is registered but not yet committed. No bypassing is done here.
- **Reset mid-operation:** in-flight output writes are dropped (we0 forced 0 immediately), busy bits clear, and pending requests must be re-presented after rst rises.

Decomposition:
- Shared package (regfile_pkg):
  - constants WIDTH_DEF=32, DEPTH_DEF=32, ADDR_W=$clog2(DEPTH_DEF), ZERO_REG=0;
  - a writeback request struct {valid, addr, data}.
- One sub-module, wb_scoreboard, holds the DEPTH busy bits, the set/clear logic with set-wins priority, and the two query ports.
- Arbitration, the starvation counter and the output register stay in the top module.

Test Plan:
1. **Basic write:** s0_valid=1, addr=5, data=0xDEADBEEF, s1 idle → s0_ready=1 in the same cycle; next cycle we0=1, wr_addr0=5, wr_din0=0xDEADBEEF; the cycle after, we0=0.
2. **Priority and starvation:** s0 (addr 3) and s1 continuously valid for 5 cycles (s1 addr 7,8,9,...) → s1 granted for 3 cycles, s0 granted on the 4th, counter returns to 0, s1 granted on the 5th.
3. **x0 write:** s1_valid addr=0, data=0x1234 → s1_ready=1; next cycle we0=0; chk_busy for address 0 stays 0 throughout.
4. **Scoreboard lifecycle:**
   - alloc_valid addr=10 → chk_addr0=10 gives chk_busy0=1.
   - s0 writes 10 → chk_busy0 stays 1 during the output cycle (we0=1, wr_addr0=10), then goes 0.
5. **Set-wins:** alloc addr=12 in the same cycle as an accepted writeback to 12 → busy[12]=1 afterwards; chk_busy1=1 with chk_addr1=12.
6. **Mid-operation reset:** s0 accepted at edge N, rst=0 asserted mid-cycle N+1 → we0 drops to 0 immediately; all chk_busy=0 and readies=0 until rst=1.
